sync_fifo_ctrl: RTL
===================

// Module: sync_fifo_ctrl
// PURPOSE
//  Single-clock, parametrised FIFO (storage + control) for same-domain buffering.
//  Successor to the async FIFO: one clock and no pointer synchronisers. Adds an
//  occupancy count, programmable almost-full/almost-empty thresholds and sticky
//  overflow/underflow error flags. Optional first-word-fall-through read mode.
// PARAMETERS
//  DATA_WIDTH  8                width of data_in/data_out
//  ADDR_WIDTH  6                DEPTH = 2**ADDR_WIDTH entries (64)
//  AF_THRESH   DEPTH-4          almost_full asserted when count >= AF_THRESH
//  AE_THRESH   4                almost_empty asserted when count <= AE_THRESH
// PORTS
//  clk           in   1             single clock; all logic on rising edge
//  rst           in   1             synchronous, active-high reset
//  wr_en         in   1             write request
//  data_in       in   DATA_WIDTH    write data
//  rd_en         in   1             read request (pop)
//  err_clr       in   1             clears sticky overflow/underflow
//  data_out      out  DATA_WIDTH    read data
//  full          out  1             count == DEPTH
//  empty         out  1             count == 0
//  almost_full   out  1             count >= AF_THRESH
//  almost_empty  out  1             count <= AE_THRESH
//  count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (rst=1 at edge): wptr=rptr=0, count=0, data_out=0, empty=1, full=0,
//    almost_empty=1, almost_full=0, overflow=underflow=0. Memory is not cleared.
//    rst mid-operation discards all contents; rst has priority over all inputs.
//  - Pointers: wptr/rptr are ADDR_WIDTH+1 bits binary; address = low ADDR_WIDTH bits.
//    Pointers wrap naturally at 2**(ADDR_WIDTH+1).
//  - Accept rules use flags of the current cycle, before the edge:
//    wr_ok = wr_en & ~full; rd_ok = rd_en & ~empty.
//  - Count update: +1 on wr_ok only, -1 on rd_ok only, unchanged when both or neither.
//  - Boundary cases:
//    - full with wr_en & rd_en: read accepted, write rejected, overflow set; count -> DEPTH-1.
//    - empty with wr_en & rd_en: write accepted, read rejected, underflow set; count -> 1.
//  - A rejected access changes no pointer, count or memory.
//  - Flags decode from the count register only, so they update on the same edge as count.
//  - overflow/underflow: set on the rejected access; hold until err_clr or rst.
//    If err_clr and a new error occur in the same cycle, the set wins.
//  - Standard read mode: data_out registered. Word popped at edge N appears at
//    edge N (valid in cycle N+1); data_out holds its value when no rd_ok.
//  - Write-to-read latency: word written at edge N is readable (empty=0) from cycle N+1.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: first-word-fall-through mode.
//    - data_out = mem[raddr] combinationally whenever empty=0; rd_ok advances to the
//      next word.
//    - data_out is undefined (don't-care) while empty=1.
//    - The reset value of data_out does not apply.
//  SYNC_FIFO_FWFT_EN undefined: standard registered-read mode as above.
//    Flags, count and error behaviour are identical in both modes.
// TESTING
//  1 Reset: after 1 cycle of rst=1 -> empty=1, almost_empty=1, full=0, count=0,
//    overflow=underflow=0, data_out=0 (standard mode).
//  2 Fill/drain: write 0x00..0x3F (64 words) -> full=1, count=64, almost_full from
//    count=60; read 64 -> data 0x00..0x3F in order, empty=1 after the last pop.
//  3 Overflow: FIFO full, wr_en=1 with data 0xAA -> overflow=1, count stays 64,
//    0xAA is never read back; err_clr=1 for 1 cycle -> overflow=0.
//  4 Simultaneous access:
//    - count=10, wr_en=rd_en=1 for 5 cycles -> count stays 10, order preserved.
//    - empty, wr_en=rd_en=1 -> count=1, underflow=1.
//  5 Wrap: 3 rounds of 40 writes followed by 40 reads -> pointers wrap, data is
//    correct, count returns to 0.
//  6 Reset mid-operation: count=20, assert rst -> count=0 and empty=1 next cycle;
//    a new write of 0x5C reads back 0x5C (both modes; FWFT shows it with no pop).

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with storage, occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise
// data_out is registered and updates on each accepted pop.
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int AF_THRESH  = (1 << ADDR_WIDTH) - 4,
  parameter int AE_THRESH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   wptr;
  logic [ADDR_WIDTH:0]   rptr;
  logic                  wr_ok;
  logic                  rd_ok;

  // Accept decisions use this cycle's flags, before the edge
  always_comb begin
    wr_ok = wr_en & ~full;
    rd_ok = rd_en & ~empty;
  end

  // Flags decode from the count register so they move with count
  always_comb begin
    full         = (count == DEPTH_C);
    empty        = (count == '0);
    almost_full  = (count >= AF_C);
    almost_empty = (count <= AE_C);
  end

  // Pointers, occupancy and sticky error flags; a new error beats err_clr
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      if (wr_ok && !rd_ok)
        count <= count + 1'b1;
      else if (rd_ok && !wr_ok)
        count <= count - 1'b1;
      overflow  <= (wr_en & full)  | (overflow  & ~err_clr);
      underflow <= (rd_en & empty) | (underflow & ~err_clr);
    end
  end

  // Storage write; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[ADDR_WIDTH-1:0]] <= data_in;
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word presented combinationally; meaningless while empty
  always_comb begin
    data_out = mem[rptr[ADDR_WIDTH-1:0]];
  end
`else
  // Registered read: popped word appears after the edge and then holds
  always_ff @(posedge clk) begin
    if (rst)
      data_out <= '0;
    else if (rd_ok)
      data_out <= mem[rptr[ADDR_WIDTH-1:0]];
  end
`endif

endmodule
